// File: rtl/wt_col_scheduler_pkg.sv
// Shared definitions for the wavelet column-pass scheduler.
//   WT_LENGTH / WT_ROWS / WT_ADDR_W : default geometry
//   wt_col_state_t                  : sequencer state encoding
package wt_col_scheduler_pkg;

   localparam int unsigned WT_LENGTH = 256;
   localparam int unsigned WT_ROWS   = 256;
   localparam int unsigned WT_ADDR_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      NEXT,
      DONE
   } wt_col_state_t;

endpackage

// File: rtl/wt_col_addr_gen.sv
// Address generator for the column pass: a column counter plus three
// row-base registers (rows 2k, 2k+1, 2k+2).
//   i_clear     : load pass-0 bases, zero the column
//   i_step      : advance the column (wraps to 0 after LENGTH-1)
//   i_next_pass : move all bases down one row pair
//   i_last_pass : final pass; lower row mirrors onto the upper row
//   o_addr_0..2 : upper / middle / lower row addresses
//   o_col_last  : column counter is at LENGTH-1
module wt_col_addr_gen
   import wt_col_scheduler_pkg::*;
#(
   parameter int unsigned LENGTH = WT_LENGTH,
   parameter int unsigned ADDR_W = WT_ADDR_W
) (
   input  logic              i_clk,
   input  logic              i_resetn,
   input  logic              i_clear,
   input  logic              i_step,
   input  logic              i_next_pass,
   input  logic              i_last_pass,
   output logic [ADDR_W-1:0] o_addr_0,
   output logic [ADDR_W-1:0] o_addr_1,
   output logic [ADDR_W-1:0] o_addr_2,
   output logic              o_col_last
);

   localparam int unsigned       COL_W     = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(LENGTH - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(LENGTH);
   localparam logic [ADDR_W-1:0] PAIR_STEP = ADDR_W'(2 * LENGTH);

   logic [COL_W-1:0]  r_col;
   logic [ADDR_W-1:0] r_base_0;
   logic [ADDR_W-1:0] r_base_1;
   logic [ADDR_W-1:0] r_base_2;
   logic [ADDR_W-1:0] w_col;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_col    <= '0;
         r_base_0 <= '0;
         r_base_1 <= '0;
         r_base_2 <= '0;
      end else if (i_clear) begin
         r_col    <= '0;
         r_base_0 <= '0;
         r_base_1 <= ROW_STEP;
         r_base_2 <= PAIR_STEP;
      end else begin
         if (i_step)
            r_col <= o_col_last ? '0 : r_col + 1'b1;
         // On the last pass r_base_2 may step past the image; it is unused then.
         if (i_next_pass) begin
            r_base_0 <= r_base_0 + PAIR_STEP;
            r_base_1 <= r_base_1 + PAIR_STEP;
            r_base_2 <= r_base_2 + PAIR_STEP;
         end
      end
   end

   assign w_col      = ADDR_W'(r_col);
   assign o_addr_0   = r_base_0 + w_col;
   assign o_addr_1   = r_base_1 + w_col;
   // Symmetric extension: row ROWS does not exist, reuse row 2k.
   assign o_addr_2   = i_last_pass ? o_addr_0 : r_base_2 + w_col;
   assign o_col_last = (r_col == COL_MAX);

endmodule

// File: rtl/wt_col_scheduler.sv
// Column-pass sequencer of the wavelet transformer. For each row pair k it
// streams three row-aligned address streams, starts the column processor,
// waits for its result and swaps the output row bank.
//   clk, resetn          : clock, async active-low reset
//   start                : begin a full-image run (IDLE only)
//   rd_en, addr_0..2     : three-port pixel memory read
//   proc_en, proc_result : column processor start pulse / completion flag
//   iter_var             : pass parity
//   row_bank_en          : output row bank swap pulse
//   pass_idx             : current pass k
//   busy, done, err      : status; err is sticky until the next run
module wt_col_scheduler
   import wt_col_scheduler_pkg::*;
#(
   parameter int unsigned LENGTH = WT_LENGTH,
   parameter int unsigned ROWS   = WT_ROWS,
   parameter int unsigned ADDR_W = WT_ADDR_W
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   output logic                        rd_en,
   output logic [ADDR_W-1:0]           addr_0,
   output logic [ADDR_W-1:0]           addr_1,
   output logic [ADDR_W-1:0]           addr_2,
   output logic                        proc_en,
   input  logic                        proc_result,
   output logic                        iter_var,
   output logic                        row_bank_en,
   output logic [$clog2(ROWS/2)-1:0]   pass_idx,
   output logic                        busy,
   output logic                        done,
   output logic                        err
);

   localparam int unsigned       PASS_W    = $clog2(ROWS / 2);
   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(ROWS / 2 - 1);

   if (((ROWS % 2) != 0) || (ROWS < 4)) begin : g_bad_rows
      $error("wt_col_scheduler: ROWS must be even and >= 4");
   end
   if ((64'(ROWS) * 64'(LENGTH)) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
      $error("wt_col_scheduler: ADDR_W too small for ROWS*LENGTH");
   end

   wt_col_state_t     r_state;
   wt_col_state_t     w_next_state;
   logic              w_accept;
   logic              w_step;
   logic              w_next_pass;
   logic              w_last_pass;
   logic              w_col_last;
   logic              r_was_issue;
   logic              r_proc_en;
   logic              r_iter;
   logic              r_err;
   logic [PASS_W-1:0] r_pass;

   assign w_last_pass = (r_pass == LAST_PASS);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      w_next_pass  = 1'b0;
      rd_en        = 1'b0;
      row_bank_en  = 1'b0;
      done         = 1'b0;
      busy         = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_accept     = 1'b1;
               w_next_state = ISSUE;
            end
         end
         ISSUE: begin
            rd_en  = 1'b1;
            w_step = 1'b1;
            if (w_col_last) w_next_state = DRAIN;
         end
         DRAIN: begin
            if (proc_result) w_next_state = NEXT;
         end
         NEXT: begin
            row_bank_en = 1'b1;
            if (w_last_pass) begin
               w_next_state = DONE;
            end else begin
               w_next_pass  = 1'b1;
               w_next_state = ISSUE;
            end
         end
         DONE: begin
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            busy         = 1'b0;
            w_next_state = IDLE;
         end
      endcase
   end

   // Every ISSUE entry is at column 0, so "first ISSUE cycle" registered
   // once lines proc_en up with column-0 read data.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_was_issue <= 1'b0;
         r_proc_en   <= 1'b0;
         r_iter      <= 1'b0;
         r_err       <= 1'b0;
         r_pass      <= '0;
      end else begin
         r_was_issue <= (r_state == ISSUE);
         r_proc_en   <= (r_state == ISSUE) && !r_was_issue;
         if (w_accept) begin
            r_err  <= 1'b0;
            r_iter <= 1'b0;
            r_pass <= '0;
         end else begin
            if (proc_result && ((r_state == ISSUE) || (r_state == NEXT)))
               r_err <= 1'b1;
            if (r_state == NEXT)
               r_iter <= ~r_iter;
            if (w_next_pass)
               r_pass <= r_pass + 1'b1;
         end
      end
   end

   assign proc_en  = r_proc_en;
   assign iter_var = r_iter;
   assign err      = r_err;
   assign pass_idx = r_pass;

   wt_col_addr_gen #(
      .LENGTH (LENGTH),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .i_clk       (clk),
      .i_resetn    (resetn),
      .i_clear     (w_accept),
      .i_step      (w_step),
      .i_next_pass (w_next_pass),
      .i_last_pass (w_last_pass),
      .o_addr_0    (addr_0),
      .o_addr_1    (addr_1),
      .o_addr_2    (addr_2),
      .o_col_last  (w_col_last)
   );

endmodule

// File: tb/tb_wt_col_scheduler.sv
module tb_wt_col_scheduler;

   localparam int L  = 8;
   localparam int R  = 4;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          resetn;
   logic          start;
   logic          rd_en;
   logic [AW-1:0] addr_0, addr_1, addr_2;
   logic          proc_en;
   logic          proc_result;
   logic          iter_var;
   logic          row_bank_en;
   logic [$clog2(R/2)-1:0] pass_idx;
   logic          busy, done, err;

   int n_checks = 0;
   int n_err    = 0;
   bit exp_err  = 0;
   bit exp_iter = 0;

   wt_col_scheduler #(
      .LENGTH (L),
      .ROWS   (R),
      .ADDR_W (AW)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .rd_en       (rd_en),
      .addr_0      (addr_0),
      .addr_1      (addr_1),
      .addr_2      (addr_2),
      .proc_en     (proc_en),
      .proc_result (proc_result),
      .iter_var    (iter_var),
      .row_bank_en (row_bank_en),
      .pass_idx    (pass_idx),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference address: row 2k+port, with the nonexistent row R mirrored to 2k.
   function automatic int ref_addr(input int port, input int k, input int c);
      int row;
      row = 2 * k + port;
      if (row >= R) row = 2 * k;
      return row * L + c;
   endfunction

   task automatic check_out(input string ph, input int k, input int c, input bit rd,
                            input bit pe, input bit rb, input bit dn, input bit bs,
                            input int pi);
      chk($sformatf("%s k%0d c%0d rd_en", ph, k, c), rd_en, rd);
      if (rd) begin
         chk($sformatf("%s k%0d c%0d addr_0", ph, k, c), addr_0, ref_addr(0, k, c));
         chk($sformatf("%s k%0d c%0d addr_1", ph, k, c), addr_1, ref_addr(1, k, c));
         chk($sformatf("%s k%0d c%0d addr_2", ph, k, c), addr_2, ref_addr(2, k, c));
      end
      chk($sformatf("%s k%0d c%0d proc_en", ph, k, c), proc_en, pe);
      chk($sformatf("%s k%0d c%0d row_bank_en", ph, k, c), row_bank_en, rb);
      chk($sformatf("%s k%0d c%0d done", ph, k, c), done, dn);
      chk($sformatf("%s k%0d c%0d busy", ph, k, c), busy, bs);
      chk($sformatf("%s k%0d c%0d pass_idx", ph, k, c), pass_idx, pi);
      chk($sformatf("%s k%0d c%0d iter_var", ph, k, c), iter_var, exp_iter);
      chk($sformatf("%s k%0d c%0d err", ph, k, c), err, exp_err);
   endtask

   // One full-image run from IDLE. lat: cycles from last data to proc_result,
   // noise: stray start pulses in ISSUE/DRAIN, force_col: pass-0 column at which
   // proc_result is forced (-1 none), force_next: proc_result high in pass-0 NEXT,
   // hold: start raised in DONE and left high.
   task automatic run_image(input int lat, input bit noise, input int force_col,
                            input bit force_next, input bit hold);
      start = 1'b1;
      tick();
      start    = 1'b0;
      exp_err  = 0;
      exp_iter = 0;
      for (int k = 0; k < R / 2; k++) begin
         for (int c = 0; c < L; c++) begin
            start       = noise && (c == 3);
            proc_result = (k == 0) && (c == force_col);
            check_out("issue", k, c, 1'b1, (c == 1), 1'b0, 1'b0, 1'b1, k);
            tick();
            if (proc_result) exp_err = 1;
            proc_result = 1'b0;
            start       = 1'b0;
         end
         for (int d = 0; d <= lat; d++) begin
            start       = noise && (d == 0);
            proc_result = (d == lat);
            check_out("drain", k, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, k);
            tick();
            proc_result = 1'b0;
            start       = 1'b0;
         end
         proc_result = force_next && (k == 0);
         check_out("next", k, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, k);
         tick();
         if (proc_result) exp_err = 1;
         proc_result = 1'b0;
         exp_iter    = !exp_iter;
      end
      check_out("done", R / 2 - 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, R / 2 - 1);
      start = hold;
      tick();
      check_out("idle", R / 2 - 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, R / 2 - 1);
   endtask

   initial begin
      resetn      = 1'b0;
      start       = 1'b0;
      proc_result = 1'b0;
      #23 resetn = 1'b1;

      // Quiet after reset
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("rst rd_en", rd_en, 0);
         chk("rst addr_0", addr_0, 0);
         chk("rst addr_1", addr_1, 0);
         chk("rst addr_2", addr_2, 0);
         chk("rst proc_en", proc_en, 0);
         chk("rst row_bank_en", row_bank_en, 0);
         chk("rst busy", busy, 0);
         chk("rst done", done, 0);
         chk("rst err", err, 0);
         chk("rst iter_var", iter_var, 0);
         chk("rst pass_idx", pass_idx, 0);
      end

      // Clean run, processor answers 3 cycles after last data
      run_image(3, 1'b0, -1, 1'b0, 1'b0);
      // Stray starts during ISSUE and DRAIN are ignored
      run_image(3, 1'b1, -1, 1'b0, 1'b0);
      // proc_result during pass-0 ISSUE -> sticky err; start held across DONE
      run_image(3, 1'b0, 2, 1'b0, 1'b1);
      // Re-armed run clears err; minimum one-cycle drain
      run_image(0, 1'b0, -1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of ISSUE (col 4)
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      chk("mid addr_0 before reset", addr_0, 4);
      #2 resetn = 1'b0;
      #1;
      chk("arst rd_en", rd_en, 0);
      chk("arst busy", busy, 0);
      chk("arst proc_en", proc_en, 0);
      chk("arst addr_0", addr_0, 0);
      chk("arst pass_idx", pass_idx, 0);
      #3 resetn = 1'b1;
      tick();
      tick();
      chk("post-arst busy", busy, 0);
      chk("post-arst rd_en", rd_en, 0);
      exp_err  = 0;
      exp_iter = 0;
      run_image(3, 1'b0, -1, 1'b0, 1'b0);

      // Randomized runs
      for (int r = 0; r < 6; r++) begin
         int lat;
         int fc;
         lat = $urandom_range(0, 6);
         fc  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, L - 1)) : -1;
         run_image(lat, 1'($urandom_range(0, 1)), fc, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      end
      start = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/wt_col_scheduler.md
Name: wt_col_scheduler

Overview:
- Sequencer for the column pass of the wavelet transformer.
- Walks an image stored in a three-read-port pixel memory, one output row pair per pass.
- Each pass issues three row-aligned address streams (rows 2k, 2k+1, 2k+2) one column per cycle.
- Pulses the column processor's start, waits for its `result`, then swaps the output row bank; repeats until the image is exhausted.

Parameters:
- LENGTH, 256 (from essentials): pixels per row = columns streamed per pass.
- ROWS, 256: image rows; must be even and ≥ 4 (elaboration-time `$error` otherwise).
- ADDR_W, 16: pixel memory address width; must satisfy 2^ADDR_W ≥ ROWS*LENGTH.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  begin full-image column pass; sampled in IDLE only.
- rd_en  out  1  memory read strobe, all three ports.
- addr_0  out  ADDR_W  address of upper row sample.
- addr_1  out  ADDR_W  address of middle row sample.
- addr_2  out  ADDR_W  address of lower row sample.
- proc_en  out  1  one-cycle start pulse to column processor, aligned with column-0 read data.
- proc_result  in  1  column processor pass-complete flag.
- iter_var  out  1  pass parity to column processor, 0 on first pass.
- row_bank_en  out  1  one-cycle output row bank swap pulse.
- pass_idx  out  $clog2(ROWS/2)  current pass k.
- busy  out  1  high from first ISSUE cycle until DONE inclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky protocol error, cleared by accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; pass and column counters 0.
- Reset is asynchronous and takes effect mid-operation. No memory or processor handshake is resumed; restart requires a new `start`.
- FSM states: IDLE, ISSUE, DRAIN, NEXT, DONE.
- IDLE: `start`=1 at edge t → ISSUE at t+1. Clears `err`, `pass_idx`, `iter_var`.
- ISSUE: `rd_en`=1 for exactly LENGTH cycles, col = 0..LENGTH-1.
  - addr_0 = (2k)*LENGTH + col
  - addr_1 = (2k+1)*LENGTH + col
  - addr_2 = (2k+2)*LENGTH + col, except when k = ROWS/2-1. Then row 2k+2 (= ROWS) is mirrored to row 2k, i.e. addr_2 = addr_0 (symmetric extension).
  - All arithmetic is unsigned ADDR_W; no wrap is possible given the parameter constraint.
  - After col = LENGTH-1 → DRAIN.
- Memory read latency is 1 cycle. `proc_en` is the registered "col==0 issued" signal, so it is high in the second ISSUE cycle, coincident with column-0 data.
- Special case LENGTH=1: `proc_en` is high in the first DRAIN cycle.
- DRAIN: wait for `proc_result`=1; no timeout. → NEXT.
- NEXT (1 cycle):
  - `row_bank_en`=1.
  - `iter_var` toggles at the end of the cycle.
  - If k = ROWS/2-1 → DONE; else k++ → ISSUE.
- DONE (1 cycle): `done`=1, `busy`=1 → IDLE.
- `proc_result`=1 sampled in ISSUE or NEXT sets `err`; the sequence still continues normally.
- `start` outside IDLE is ignored; it is not queued and does not set `err`.
- `start` held high across DONE → IDLE → re-arm: a new run begins one cycle after IDLE is entered.
- Pass timing: LENGTH + D + 1 cycles per pass, where D ≥ 1 is the number of DRAIN cycles.

Decomposition:
- Package essentials: LENGTH, ROWS default, and state typedef `wt_col_state_t` (IDLE, ISSUE, DRAIN, NEXT, DONE).
- One sub-module, wt_col_addr_gen: column counter plus three row-base registers with the mirror rule.
  - Inputs: clear, step, next_pass, last_pass.
  - Outputs: addr_0..2, col_last.
- The FSM and flags stay in wt_col_scheduler.

Test Plan (LENGTH=8, ROWS=4, processor model asserts `proc_result` 3 cycles after last data):
- Reset held then released, no start → all outputs 0 for 20 cycles; `busy`=0.
- Start pulse → pass 0: addr_0/1/2 sweep 0..7 / 8..15 / 16..23 with `rd_en`=1 for 8 cycles; `proc_en`=1 exactly once, in the cycle after addr_0=0; `row_bank_en` pulse after `proc_result`; `iter_var` 0→1.
- Continue → pass 1: addr_0 16..23, addr_1 24..31, addr_2 mirrored 16..23; then `row_bank_en` pulse, `done`=1 one cycle, `busy` falls next cycle, `pass_idx` returns to 0 on next start.
- `start` pulsed during ISSUE and DRAIN → ignored; address sequence and `done` timing identical to the clean run; `err`=0.
- `proc_result` forced high during pass-0 ISSUE → `err`=1 and remains 1 through `done`; next accepted start clears it.
- `resetn` dropped asynchronously mid-ISSUE (col=4) → `rd_en`, `busy`, `proc_en` low immediately; after release and a new start, pass 0 restarts at address 0.
